// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Holds the controller state encoding and the counter step function.
package bp_pkg;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_t;

  // Saturating +/-1 on a counter of 'bits' width (bits <= 32).
  function automatic logic [31:0] sat_step(
    input logic [31:0] ctr,
    input logic        up,
    input int unsigned bits
  );
    logic [31:0] max_v;
    max_v = (bits >= 32) ? 32'hFFFF_FFFF
                         : ((32'd1 << bits) - 32'd1);
    if (up)
      return (ctr >= max_v) ? max_v : ctr + 32'd1;
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// BHT: flop array of saturating counters.
// One async read port, one sync write port (init or training).
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                init_en,
  input  logic [IDX_BITS-1:0] init_idx,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_up,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr
);

  localparam int SIZE = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] WEAK_NT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] mem [SIZE];

  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic [CTR_BITS-1:0] wr_data;

  // Read sees the pre-write value within the cycle.
  assign rd_ctr = mem[rd_idx];

  // Select the single write: init fill or a trained counter.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    unique case (1'b1)
      init_en: begin
        wr_en   = 1'b1;
        wr_idx  = init_idx;
        wr_data = WEAK_NT;
      end
      upd_en: begin
        wr_en   = 1'b1;
        wr_idx  = upd_idx;
        wr_data = CTR_BITS'(sat_step(
          32'(mem[upd_idx]), upd_up, CTR_BITS));
      end
      default: ;
    endcase
  end

  // Counter storage; contents are defined by the init sweep.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/gshare_predictor_v2.sv
// gshare direction predictor: IF-side lookup, EX-side training.
// Speculative GHR with snapshot repair on mispredict.
module gshare_predictor_v2
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int GHR_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int PC_SHIFT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  output logic [GHR_BITS-1:0] pred_ghr,
  output logic                ready,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  output logic [31:0]         mispred_cnt
);

  localparam int BHT_SIZE = 1 << IDX_BITS;

  bp_state_t           state_q;
  bp_state_t           state_d;
  logic [IDX_BITS-1:0] init_ptr;
  logic [GHR_BITS-1:0] spec_ghr;
  logic [IDX_BITS-1:0] ghr_ext;
  logic [CTR_BITS-1:0] rd_ctr;
  logic                run;
  logic                repair;
  logic                unused_bits;

  assign run    = (state_q == BP_RUN);
  assign repair = run && upd_valid && upd_mispredict;
  assign ready  = run;

  assign unused_bits = ^{pred_pc[31:IDX_BITS+PC_SHIFT],
                         pred_pc[PC_SHIFT-1:0],
                         upd_ghr[GHR_BITS-1]};

  // Zero-extend the history to the index width.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = spec_ghr;
  end

  assign pred_idx =
    pred_pc[IDX_BITS+PC_SHIFT-1:PC_SHIFT] ^ ghr_ext;
  assign pred_ghr   = spec_ghr;
  assign pred_taken = run & rd_ctr[CTR_BITS-1];

  // Controller state register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)
      state_q <= BP_INIT;
    else
      state_q <= state_d;
  end

  // Leave INIT after the last entry has been written.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BP_INIT:
        if (init_ptr == IDX_BITS'(BHT_SIZE - 1))
          state_d = BP_RUN;
      BP_RUN: ;
      default: state_d = BP_INIT;
    endcase
  end

  // Init sweep pointer, one entry per cycle.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)
      init_ptr <= '0;
    else if (!run)
      init_ptr <= init_ptr + IDX_BITS'(1);
  end

  // Speculative history; a repair beats a same-cycle shift.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)
      spec_ghr <= '0;
    else if (repair)
      spec_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
    else if (run && pred_valid)
      spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken};
  end

  // Saturating mispredict statistic.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)
      mispred_cnt <= '0;
    else if (repair && mispred_cnt != '1)
      mispred_cnt <= mispred_cnt + 32'd1;
  end

  bp_counter_table #(
    .IDX_BITS(IDX_BITS),
    .CTR_BITS(CTR_BITS)
  ) u_bht (
    .clk     (clk),
    .init_en (!run),
    .init_idx(init_ptr),
    .upd_en  (run && upd_valid),
    .upd_idx (upd_idx),
    .upd_up  (upd_taken),
    .rd_idx  (pred_idx),
    .rd_ctr  (rd_ctr)
  );

endmodule

// File: tb/tb_gshare_predictor_v2.sv
// Directed bench for gshare_predictor_v2.
// Hand-computed vectors for init, hash, training, GHR repair.
module tb_gshare_predictor_v2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [7:0]  pred_idx;
  logic [7:0]  pred_ghr;
  logic        ready;
  logic        upd_valid;
  logic [7:0]  upd_idx;
  logic [7:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  gshare_predictor_v2 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_idx      (pred_idx),
    .pred_ghr      (pred_ghr),
    .ready         (ready),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_ghr       (upd_ghr),
    .upd_taken     (upd_taken),
    .upd_mispredict(upd_mispredict),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs may change 2 units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic upd(input logic v, input logic [7:0] idx,
                     input logic t, input logic m,
                     input logic [7:0] g);
    upd_valid      = v;
    upd_idx        = idx;
    upd_taken      = t;
    upd_mispredict = m;
    upd_ghr        = g;
  endtask

  initial begin
    reset_n    = 1'b1;
    pred_valid = 1'b0;
    pred_pc    = '0;
    upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    #1;
    check("rst_ready", 32'(ready), 0);
    check("rst_taken", 32'(pred_taken), 0);
    check("rst_ghr", 32'(pred_ghr), 0);
    check("rst_cnt", mispred_cnt, 0);

    // Interrupt INIT at cycle 100.
    reset_n = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("mid_ptr_pre", 32'(dut.init_ptr), 100);
    reset_n = 1'b1;
    #1;
    check("mid_ptr", 32'(dut.init_ptr), 0);
    check("mid_ready", 32'(ready), 0);
    tick();
    reset_n = 1'b0;

    // Full INIT: ready low for 256 cycles, updates ignored.
    for (int i = 0; i < 256; i++) begin
      pred_pc = 32'(i) << 2;
      if (i >= 5 && i <= 8)
        upd(1'b1, 8'h02, 1'b1, 1'b1, 8'hFF);
      else
        upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      #1;
      if (ready !== 1'b0 || pred_taken !== 1'b0)
        check($sformatf("init_c%0d", i),
              32'({ready, pred_taken}), 0);
      tick();
    end
    #1;
    check("init_ready", 32'(ready), 1);
    check("init_ghr", 32'(pred_ghr), 0);
    check("init_cnt", mispred_cnt, 0);
    for (int i = 0; i < 256; i++)
      if (dut.u_bht.mem[i] !== 2'b01)
        check($sformatf("bht_%0d", i),
              32'(dut.u_bht.mem[i]), 1);
    check("bht_02", 32'(dut.u_bht.mem[2]), 1);
    check("bht_ff", 32'(dut.u_bht.mem[255]), 1);

    // Hash and taken training at 0x10.
    pred_pc = 32'h40;
    #1;
    check("hash_idx", 32'(pred_idx), 32'h10);
    check("hash_taken0", 32'(pred_taken), 0);
    upd(1'b1, 8'h10, 1'b1, 1'b0, 8'h00);
    tick();
    #1;
    check("tr1_ctr", 32'(dut.u_bht.mem[16]), 2);
    check("tr1_taken", 32'(pred_taken), 1);
    tick();
    #1;
    check("tr2_ctr", 32'(dut.u_bht.mem[16]), 3);
    tick();
    #1;
    check("tr3_ctr", 32'(dut.u_bht.mem[16]), 3);
    upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Speculative shifts 1,0,1 from ghr 0.
    pred_valid = 1'b1;
    pred_pc    = 32'h40;
    #1;
    check("sp1_taken", 32'(pred_taken), 1);
    tick();
    pred_pc = 32'h0;
    #1;
    check("sp2_ghr", 32'(pred_ghr), 1);
    check("sp2_idx", 32'(pred_idx), 1);
    check("sp2_taken", 32'(pred_taken), 0);
    tick();
    pred_pc = 32'h48;
    #1;
    check("sp3_ghr", 32'(pred_ghr), 2);
    check("sp3_idx", 32'(pred_idx), 32'h10);
    check("sp3_taken", 32'(pred_taken), 1);
    tick();
    pred_valid = 1'b0;
    #1;
    check("sp_ghr", 32'(pred_ghr), 32'h05);

    // Repair from snapshot.
    upd(1'b1, 8'h20, 1'b1, 1'b1, 8'h00);
    tick();
    #1;
    check("rep_ghr", 32'(pred_ghr), 32'h01);
    check("rep_cnt", mispred_cnt, 1);
    check("rep_ctr", 32'(dut.u_bht.mem[32]), 2);

    // Repair wins over same-cycle shift.
    pred_valid = 1'b1;
    pred_pc    = 32'h40;
    upd(1'b1, 8'h20, 1'b0, 1'b1, 8'hF0);
    tick();
    pred_valid = 1'b0;
    upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    #1;
    check("win_ghr", 32'(pred_ghr), 32'hE0);
    check("win_cnt", mispred_cnt, 2);

    // Mispredict flag without valid is ignored.
    upd(1'b0, 8'h00, 1'b1, 1'b1, 8'h33);
    tick();
    upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    #1;
    check("nov_ghr", 32'(pred_ghr), 32'hE0);
    check("nov_cnt", mispred_cnt, 2);

    // Read-before-write on index 0x30.
    pred_valid = 1'b1;
    pred_pc    = 32'h340;
    upd(1'b1, 8'h30, 1'b1, 1'b0, 8'h00);
    #1;
    check("rbw_idx", 32'(pred_idx), 32'h30);
    check("rbw_taken0", 32'(pred_taken), 0);
    tick();
    pred_valid = 1'b0;
    pred_pc    = 32'h3C0;
    upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    #1;
    check("rbw_ghr", 32'(pred_ghr), 32'hC0);
    check("rbw_idx2", 32'(pred_idx), 32'h30);
    check("rbw_taken1", 32'(pred_taken), 1);

    // Not-taken training saturates at 0.
    upd(1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
    tick();
    #1;
    check("nt1_ctr", 32'(dut.u_bht.mem[64]), 0);
    tick();
    #1;
    check("nt2_ctr", 32'(dut.u_bht.mem[64]), 0);
    tick();
    #1;
    check("nt3_ctr", 32'(dut.u_bht.mem[64]), 0);
    upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gshare_predictor_v2.md
Name: gshare_predictor_v2

Overview:
Parametrised gshare direction predictor with split predict and update ports, so the fetch-stage lookup and the execute-stage training are independent. It keeps a speculative global history register (GHR), updated at predict time and repaired on mispredict from a snapshot the pipeline carries with each branch. At reset it clears its branch history table (BHT) with an init state machine. It sits between IF (predict) and EX (resolve) in the core.

Parameters:
IDX_BITS, 8, BHT index width; BHT_SIZE = 2**IDX_BITS (localparam)
GHR_BITS, 8, global history length; must satisfy 2 <= GHR_BITS <= IDX_BITS
CTR_BITS, 2, saturating counter width; must be >= 1
PC_SHIFT, 2, low PC bits dropped before hashing (instruction alignment)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-high
pred_valid  in  1  fetch presents a branch PC this cycle
pred_pc  in  32  fetch PC
pred_taken  out  1  predicted direction (combinational)
pred_idx  out  IDX_BITS  BHT index used; carried down the pipeline
pred_ghr  out  GHR_BITS  spec GHR before this prediction; carried down the pipeline
ready  out  1  BHT init done; predictions valid
upd_valid  in  1  branch resolved this cycle
upd_idx  in  IDX_BITS  pred_idx carried with the branch
upd_ghr  in  GHR_BITS  pred_ghr carried with the branch
upd_taken  in  1  actual outcome
upd_mispredict  in  1  predicted direction was wrong
mispred_cnt  out  32  saturating mispredict counter

Behaviour:
- Reset asserted (reset_n high): spec_ghr=0, state=INIT, init_ptr=0, ready=0, mispred_cnt=0, pred_taken=0.
- Reset asserted mid-operation restarts INIT from entry 0.
- INIT: each cycle writes bht[init_ptr] = WEAK_NT = 2**(CTR_BITS-1)-1 and increments init_ptr.
  - After the write of entry BHT_SIZE-1, state moves to RUN; ready=1 from the next cycle.
  - INIT lasts exactly BHT_SIZE cycles.
  - Update port ignored in INIT; pred_taken=0 in INIT; spec_ghr not shifted in INIT.
- Hash: index = pred_pc[IDX_BITS+PC_SHIFT-1:PC_SHIFT] XOR zero-extended spec_ghr.
  - pred_idx = index; pred_ghr = spec_ghr; pred_taken = MSB of bht[index].
  - All three are combinational, 0-cycle latency.
- Speculative shift (RUN): if pred_valid, then at the clock edge spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken}.
- Training (RUN): if upd_valid, bht[upd_idx] counts +1 when upd_taken, -1 otherwise.
  - Saturates at 0 and 2**CTR_BITS-1.
- Repair (RUN): if upd_valid && upd_mispredict, spec_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - Repair overrides a same-cycle speculative shift.
  - mispred_cnt increments, saturating at 32'hFFFF_FFFF.
- Same-cycle predict and update to the same index: predict reads the pre-update value (read-before-write); the new value is visible next cycle.
- upd_mispredict without upd_valid is ignored.
- BHT is a flop array with one write port. A write is either the init write or the training write; these never coincide.

Decomposition:
- Package bp_pkg:
  - typedef enum {BP_INIT, BP_RUN} bp_state_t
  - function sat_step(ctr, up) for parametrised saturating increment/decrement
- Sub-module bp_counter_table: BHT_SIZE x CTR_BITS array with one async read port and one sync write port. It holds the init write mux and saturation logic. The top module holds the FSM, GHR, hash and stat counter.

Test Plan:
- Reset, then hold idle: ready=0 for 256 cycles and 1 on cycle 257; every entry reads 2'b01; pred_taken=0 throughout INIT.
- Assert reset at INIT cycle 100: init_ptr returns to 0; ready rises 256 cycles after release.
- pc=0x40, ghr=0: pred_idx=0x10. Train taken 3x at idx 0x10: counter 01→10→11→11; pred_taken=1 after the first update.
- pred_valid for 3 cycles with predictions 1,0,1 from ghr=0: spec_ghr=8'b00000101. Then upd_mispredict with upd_ghr=0x00, upd_taken=1: spec_ghr=0x01; mispred_cnt=1.
- Same cycle: pred_valid, plus upd_valid with upd_mispredict and upd_ghr=0xF0, upd_taken=0: spec_ghr=0xE0 (repair wins).
- Same-index predict+update on counter 01 with taken: pred_taken=0 that cycle and 1 the next. Train not-taken 3x from 01: 01→00→00.
